int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt request controller that produces the Int_Enter / IRS / t signals consumed by the ID/EX pipeline register.
- Consumes the retiring uret pulse from EX to unwind service state.
- Synchronises three external request lines, latches pending requests, and arbitrates by fixed priority, with nested preemption up to depth 3.
- Sits beside the ID stage; its Int_Enter flushes the ID/EX control fields and redirects PC to the handler vector t.

Parameters:
- WIDTH, 32, datapath/vector width.
- VEC1, 32'h0000_3000, handler address for source 1 (int_req[0]).
- VEC2, 32'h0000_3100, handler address for source 2 (int_req[1]).
- VEC3, 32'h0000_3200, handler address for source 3 (int_req[2]).
- HOLDOFF, 3, cycles after an entry during which no new entry is issued (pipeline redirect window), range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  pipeline can accept an entry this cycle (not stalled); an entry fires only when en=1.
- ie  in  1  global interrupt enable (CSR ustatus.UIE).
- int_req  in  3  raw request lines, asynchronous, active-high level; a rising edge constitutes a request.
- uret  in  1  one-cycle pulse: uret retiring in EX.
- Int_Enter  out  1  one-cycle entry pulse.
- IRS  out  3  one-hot source of the most recent entry; held until the next entry.
- t  out  WIDTH  handler vector for IRS.
- pending  out  3  latched, not-yet-serviced requests.
- in_service  out  3  sources currently inside a handler (nesting stack).

Behaviour:
- Reset (rst=0, async) clears all of the following to 0: sync flops, edge history, pending, in_service, Int_Enter, IRS, t, holdoff counter; FSM goes to IDLE. Reset asserted mid-handler or mid-holdoff discards all state immediately.
- Synchronisation: 2-flop synchroniser per line, plus a third flop for edge detect. A rising edge on int_req[i] sets pending[i] 3 cycles after the raw edge. Level held high does not re-trigger.
- Priority: index 2 > 1 > 0. level = index of the highest set in_service bit + 1, or 0 if in_service==0.
- Eligible source i: pending[i] && ie && (i+1 > level). winner = highest eligible index.
- FSM states:
  - IDLE: if winner exists && en && !uret, go to ENTER.
  - ENTER (1 cycle):
    - Int_Enter=1.
    - IRS=onehot(winner); t=VEC of winner; both registered and held afterwards.
    - pending[winner] cleared; in_service[winner] set.
    - Holdoff counter loaded with HOLDOFF; go to HOLD.
  - HOLD: counter decrements each cycle; at 0 return to IDLE. No entry is issued in HOLD; pending bits still latch.
- Winner is sampled in IDLE and frozen into ENTER; a higher source arriving during ENTER waits for IDLE.
- uret (any state): clears the highest set in_service bit. uret with in_service==0 is ignored. In a cycle where uret=1, IDLE does not enter; re-evaluate next cycle against the updated level.
- Simultaneous new edge on source i and clearing of pending[i] in ENTER: pending[i] stays 1 (new edge wins).
- en=0 holds FSM in IDLE with pending retained; no requests are lost.
- ie=0 blocks entry only; pending still latches and in_service still unwinds on uret.
- Equal or lower priority never preempts; it waits until level drops below it.
- Int_Enter is never asserted in two consecutive cycles; the minimum gap between entries is HOLDOFF+1 cycles.
- Nesting depth is bounded at 3 by construction (each source at most once in service).

Test Plan:
- Reset, ie=1, en=1; int_req[0] 0→1 at cycle 10 → pending=001 at cycle 13; Int_Enter=1 at cycle 14; IRS=001, t=32'h3000, in_service=001, pending=000.
- Source 1 in service; int_req[2] rises → entry with IRS=100, t=32'h3200, in_service=101; then uret → in_service=001; second uret → 000.
- Source 2 in service; int_req[0] and int_req[1] rise → no entry (lower/equal priority); after uret, source 1 enters, then source 0 only after HOLDOFF+1 ≥ 4 cycles and a second uret.
- int_req[0] and int_req[2] rise in the same cycle → IRS=100 first; pending=001 retained; source 0 enters only after uret drops level to 0.
- ie=0 or en=0 with pending=010 for 20 cycles → no Int_Enter, pending stays 010; raise ie/en → Int_Enter the next cycle; a uret with in_service=000 leaves all outputs unchanged.
- rst asserted during HOLD with in_service=011 → all outputs 0 asynchronously; after release, no spurious entry while int_req is held high (no new edge).

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt request controller beside the ID stage.
// Synchronises three asynchronous request lines and latches their rising edges
// as pending requests. The highest-priority eligible source is arbitrated
// against the current nesting level. An entry raises Int_Enter for one cycle
// with the source (IRS) and handler vector (t). A holdoff window after each
// entry covers the pipeline redirect. uret pops the innermost active handler.
`timescale 1ns/1ps
module int_ctrl #(
  parameter int unsigned       WIDTH   = 32,
  parameter logic [WIDTH-1:0]  VEC1    = 32'h0000_3000,
  parameter logic [WIDTH-1:0]  VEC2    = 32'h0000_3100,
  parameter logic [WIDTH-1:0]  VEC3    = 32'h0000_3200,
  parameter int unsigned       HOLDOFF = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ie,
  input  logic [2:0]       int_req,
  input  logic             uret,
  output logic             Int_Enter,
  output logic [2:0]       IRS,
  output logic [WIDTH-1:0] t,
  output logic [2:0]       pending,
  output logic [2:0]       in_service
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

  // Nesting level: 1 + index of the innermost (highest) active handler, 0 if none.
  function automatic logic [1:0] level_of(input logic [2:0] ins);
    logic [1:0] lvl;
    if (ins[2]) begin
      lvl = 2'd3;
    end else if (ins[1]) begin
      lvl = 2'd2;
    end else if (ins[0]) begin
      lvl = 2'd1;
    end else begin
      lvl = 2'd0;
    end
    return lvl;
  endfunction

  // One-hot of the highest set bit (fixed priority 2 > 1 > 0).
  function automatic logic [2:0] top_onehot(input logic [2:0] v);
    logic [2:0] oh;
    if (v[2]) begin
      oh = 3'b100;
    end else if (v[1]) begin
      oh = 3'b010;
    end else if (v[0]) begin
      oh = 3'b001;
    end else begin
      oh = 3'b000;
    end
    return oh;
  endfunction

  // Handler vector for a one-hot source.
  function automatic logic [WIDTH-1:0] vec_of(input logic [2:0] oh);
    logic [WIDTH-1:0] v;
    case (oh)
      3'b001:  v = VEC1;
      3'b010:  v = VEC2;
      3'b100:  v = VEC3;
      default: v = {WIDTH{1'b0}};
    endcase
    return v;
  endfunction

  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [2:0] sync3_r;
  logic [1:0] warm_r;
  state_t     state_r;
  logic [3:0] hold_cnt_r;

  logic [2:0] edge_s;
  logic [1:0] level_s;
  logic [2:0] eligible_s;
  logic [2:0] winner_s;
  logic [2:0] uret_clear_s;
  logic       enter_s;
  logic [2:0] enter_mask_s;

  // Two-flop synchroniser plus edge-history flop; warm_r masks edges until the
  // history flop holds a real post-reset sample, so a level held across reset
  // is not mistaken for a fresh request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      sync3_r <= 3'b000;
      warm_r  <= 2'd0;
    end else begin
      sync1_r <= int_req;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      if (warm_r != 2'd3) begin
        warm_r <= warm_r + 2'd1;
      end else begin
        warm_r <= warm_r;
      end
    end
  end

  // Edge detect, eligibility, arbitration, uret unwind and entry decision.
  always_comb begin
    edge_s       = 3'b000;
    level_s      = level_of(in_service);
    eligible_s   = 3'b000;
    winner_s     = 3'b000;
    uret_clear_s = 3'b000;
    enter_s      = 1'b0;
    enter_mask_s = 3'b000;

    if (warm_r == 2'd3) begin
      edge_s = sync2_r & ~sync3_r;
    end else begin
      edge_s = 3'b000;
    end

    // A source may only preempt a strictly lower nesting level.
    eligible_s[0] = pending[0] & ie & (level_s == 2'd0);
    eligible_s[1] = pending[1] & ie & (level_s <= 2'd1);
    eligible_s[2] = pending[2] & ie & (level_s <= 2'd2);
    winner_s      = top_onehot(eligible_s);

    if (uret) begin
      uret_clear_s = top_onehot(in_service);
    end else begin
      uret_clear_s = 3'b000;
    end

    // No entry in a uret cycle: the level is re-evaluated once it has dropped.
    if ((state_r == ST_IDLE) && (winner_s != 3'b000) && en && !uret) begin
      enter_s      = 1'b1;
      enter_mask_s = winner_s;
    end else begin
      enter_s      = 1'b0;
      enter_mask_s = 3'b000;
    end
  end

  // Pending latch and nesting stack; a new edge on the entering source wins
  // over its clear so back-to-back requests are never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= 3'b000;
      in_service <= 3'b000;
    end else begin
      pending    <= (pending & ~enter_mask_s) | edge_s;
      in_service <= (in_service & ~uret_clear_s) | enter_mask_s;
    end
  end

  // Entry FSM with registered entry pulse, source and vector; the holdoff
  // counter is loaded on entry and counts down through ENTER and HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= 4'd0;
      Int_Enter  <= 1'b0;
      IRS        <= 3'b000;
      t          <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enter_s) begin
            state_r    <= ST_ENTER;
            hold_cnt_r <= HOLD_LOAD;
            Int_Enter  <= 1'b1;
            IRS        <= enter_mask_s;
            t          <= vec_of(enter_mask_s);
          end else begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 4'd0;
            Int_Enter  <= 1'b0;
          end
        end
        ST_ENTER, ST_HOLD: begin
          Int_Enter <= 1'b0;
          if (hold_cnt_r <= 4'd1) begin
            hold_cnt_r <= 4'd0;
            state_r    <= ST_IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r - 4'd1;
            state_r    <= ST_HOLD;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          hold_cnt_r <= 4'd0;
          Int_Enter  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: a cycle-level reference model built from the
// controller's rules predicts every entry and the visible request state.
`timescale 1ns/1ps
module tb_int_ctrl;

  localparam int          WIDTH   = 32;
  localparam int          HOLDOFF = 3;
  localparam logic [31:0] V1      = 32'h0000_3000;
  localparam logic [31:0] V2      = 32'h0000_3100;
  localparam logic [31:0] V3      = 32'h0000_3200;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        en      = 1'b0;
  logic        ie      = 1'b0;
  logic [2:0]  int_req = 3'b000;
  logic        uret    = 1'b0;
  logic        Int_Enter;
  logic [2:0]  IRS;
  logic [31:0] t;
  logic [2:0]  pending;
  logic [2:0]  in_service;

  int_ctrl #(.WIDTH(WIDTH), .VEC1(V1), .VEC2(V2), .VEC3(V3), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .en(en), .ie(ie), .int_req(int_req), .uret(uret),
    .Int_Enter(Int_Enter), .IRS(IRS), .t(t), .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  irs;
    logic [31:0] vec;
    logic [2:0]  ins;
    logic [2:0]  pend;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // reference model state
  logic [2:0]  m_pend, m_ins, m_irs, m_prev;
  logic [31:0] m_t;
  logic        m_enter;
  logic        m_first;
  int          m_since;
  logic [2:0]  m_edq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int top_bit(input logic [2:0] v);
    for (int b = 2; b >= 0; b--) begin
      if (v[b]) return b;
    end
    return -1;
  endfunction

  function automatic logic [31:0] handler(input int src);
    case (src)
      0:       return V1;
      1:       return V2;
      default: return V3;
    endcase
  endfunction

  task automatic model_reset();
    m_pend  = 3'b000; m_ins = 3'b000; m_irs = 3'b000; m_prev = 3'b000;
    m_t     = 32'h0;  m_enter = 1'b0; m_first = 1'b1;
    m_since = HOLDOFF;
    m_edq   = {3'b000, 3'b000};
    exp_q.delete();
  endtask

  // One clock of the rules: edges reach pending three cycles after the raw
  // change, entries need the holdoff window elapsed, uret pops the innermost.
  task automatic model_step(input logic [2:0] req, input logic e, input logic i, input logic u);
    int         lvl, win;
    logic [2:0] newedge, applied, mask, one;
    exp_t       ex;
    lvl = top_bit(m_ins) + 1;
    win = -1;
    for (int s = 2; s >= 0; s--) begin
      if (win < 0 && m_pend[s] && i && (s + 1 > lvl)) win = s;
    end
    if (m_first) newedge = 3'b000;
    else         newedge = req & ~m_prev;
    m_first = 1'b0;
    m_prev  = req;
    m_edq.push_back(newedge);
    applied = m_edq.pop_front();
    one  = 3'b001;
    mask = 3'b000;
    if (win >= 0 && e && !u && m_since >= HOLDOFF) mask = one << win;
    if (u && m_ins != 3'b000) m_ins[top_bit(m_ins)] = 1'b0;
    m_ins   = m_ins | mask;
    m_pend  = (m_pend & ~mask) | applied;
    m_enter = (mask != 3'b000);
    if (m_enter) begin
      m_irs   = mask;
      m_t     = handler(win);
      m_since = 0;
      ex.irs  = m_irs; ex.vec = m_t; ex.ins = m_ins; ex.pend = m_pend;
      exp_q.push_back(ex);
    end else if (m_since < 1000) begin
      m_since++;
    end
  endtask

  // Called at a negedge: compare visible state, apply inputs, advance model.
  task automatic do_cycle(input logic [2:0] req, input logic e, input logic i, input logic u);
    chk("int_enter", 32'(Int_Enter), 32'(m_enter));
    chk("irs", 32'(IRS), 32'(m_irs));
    chk("t", t, m_t);
    chk("pending", 32'(pending), 32'(m_pend));
    chk("in_service", 32'(in_service), 32'(m_ins));
    int_req = req; en = e; ie = i; uret = u;
    model_step(req, e, i, u);
  endtask

  task automatic drive_run(input logic [2:0] req, input logic e, input logic i, input logic u, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      do_cycle(req, e, i, u);
    end
  endtask

  task automatic release_reset(input logic [2:0] req);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_cycle(req, 1'b1, 1'b1, 1'b0);
  endtask

  // Monitor: every entry the DUT presents must match the next prediction.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #2;
      if (rst === 1'b1 && Int_Enter === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry actual IRS=%0b t=%0h expected no entry at %0t", IRS, t, $time);
        end else begin
          ex = exp_q.pop_front();
          chk("entry_irs", 32'(IRS), 32'(ex.irs));
          chk("entry_t", t, ex.vec);
          chk("entry_in_service", 32'(in_service), 32'(ex.ins));
          chk("entry_pending", 32'(pending), 32'(ex.pend));
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    release_reset(3'b000);

    // single request: edge -> pending after 3 cycles -> entry next cycle
    drive_run(3'b000, 1'b1, 1'b1, 1'b0, 9);
    drive_run(3'b001, 1'b1, 1'b1, 1'b0, 10);
    drive_run(3'b001, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b001, 1'b1, 1'b1, 1'b0, 3);

    // async reset in HOLD with two nested handlers, level held across reset
    drive_run(3'b000, 1'b1, 1'b1, 1'b0, 4);
    drive_run(3'b001, 1'b1, 1'b1, 1'b0, 8);
    drive_run(3'b011, 1'b1, 1'b1, 1'b0, 5);
    @(posedge clk);
    #1;
    chk("pre_rst_in_service", 32'(in_service), 32'h3);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_int_enter", 32'(Int_Enter), 32'h0);
    chk("rst_irs", 32'(IRS), 32'h0);
    chk("rst_t", t, 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_in_service", 32'(in_service), 32'h0);
    int_req = 3'b111;
    repeat (2) @(negedge clk);
    release_reset(3'b111);
    drive_run(3'b111, 1'b1, 1'b1, 1'b0, 15);

    // preemption by a higher source, then unwinding
    drive_run(3'b000, 1'b1, 1'b1, 1'b0, 3);
    drive_run(3'b001, 1'b1, 1'b1, 1'b0, 8);
    drive_run(3'b101, 1'b1, 1'b1, 1'b0, 8);
    drive_run(3'b101, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b101, 1'b1, 1'b1, 1'b0, 3);
    drive_run(3'b101, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b101, 1'b1, 1'b1, 1'b0, 3);

    // equal/lower priority waits for the level to drop
    drive_run(3'b000, 1'b1, 1'b1, 1'b0, 3);
    drive_run(3'b010, 1'b1, 1'b1, 1'b0, 8);
    drive_run(3'b000, 1'b1, 1'b1, 1'b0, 3);
    drive_run(3'b011, 1'b1, 1'b1, 1'b0, 10);
    drive_run(3'b011, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b011, 1'b1, 1'b1, 1'b0, 8);
    drive_run(3'b011, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b011, 1'b1, 1'b1, 1'b0, 8);
    drive_run(3'b011, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b011, 1'b1, 1'b1, 1'b0, 3);

    // simultaneous edges on sources 0 and 2
    drive_run(3'b000, 1'b1, 1'b1, 1'b0, 3);
    drive_run(3'b101, 1'b1, 1'b1, 1'b0, 10);
    drive_run(3'b101, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b101, 1'b1, 1'b1, 1'b0, 8);
    drive_run(3'b101, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b101, 1'b1, 1'b1, 1'b0, 3);

    // ie=0 and en=0 hold off entry without losing the request
    drive_run(3'b000, 1'b1, 1'b0, 1'b0, 3);
    drive_run(3'b010, 1'b1, 1'b0, 1'b0, 20);
    drive_run(3'b010, 1'b1, 1'b1, 1'b0, 3);
    drive_run(3'b010, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b000, 1'b0, 1'b1, 1'b0, 3);
    drive_run(3'b010, 1'b0, 1'b1, 1'b0, 20);
    drive_run(3'b010, 1'b1, 1'b1, 1'b0, 3);
    drive_run(3'b010, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b010, 1'b1, 1'b1, 1'b0, 5);
    drive_run(3'b010, 1'b1, 1'b1, 1'b1, 1);
    drive_run(3'b010, 1'b1, 1'b1, 1'b0, 3);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] nr;
      logic       ne, ni, nu;
      nr = int_req ^ {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      ne = ($urandom_range(0, 9) != 0);
      ni = ($urandom_range(0, 11) != 0);
      nu = ($urandom_range(0, 7) == 0);
      drive_run(nr, ne, ni, nu, 1);
    end

    // drain: unwind everything and let pending entries complete
    for (int c = 0; c < 6; c++) begin
      drive_run(int_req, 1'b1, 1'b1, 1'b0, 6);
      drive_run(int_req, 1'b1, 1'b1, 1'b1, 1);
    end
    drive_run(int_req, 1'b1, 1'b1, 1'b0, 4);
    chk("queue_drain", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
